// File: rtl/mcc_pkg.sv
// ---------------------------------------------------------------------------
// mcc_pkg
// Shared definitions for the multicycle CPU sequencer (multi_cycle_ctrl):
//   - FSM state encoding (localparams + typedef enum)
//   - opcode constants (IR[31:26])
//   - instruction class enum produced by mcc_op_decode
//   - pc_src mux select codes
// No ports; imported by mcc_op_decode and multi_cycle_ctrl.
// ---------------------------------------------------------------------------
package mcc_pkg;

    // State encoding
    localparam logic [2:0] ST_IF   = 3'd0;
    localparam logic [2:0] ST_ID   = 3'd1;
    localparam logic [2:0] ST_EXE  = 3'd2;
    localparam logic [2:0] ST_MEM  = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    typedef enum logic [2:0] {
        S_IF   = ST_IF,
        S_ID   = ST_ID,
        S_EXE  = ST_EXE,
        S_MEM  = ST_MEM,
        S_WB   = ST_WB,
        S_HALT = ST_HALT
    } state_e;

    // Opcodes; ALU instructions are any opcode of the form 00xxxx
    localparam logic [1:0] OP_ALU_HI = 2'b00;
    localparam logic [5:0] OP_SW     = 6'b110000;
    localparam logic [5:0] OP_LW     = 6'b110001;
    localparam logic [5:0] OP_BEQ    = 6'b110100;
    localparam logic [5:0] OP_J      = 6'b111000;
    localparam logic [5:0] OP_HALT   = 6'b111111;

    // Instruction classes
    typedef enum logic [2:0] {
        CLS_ALU  = 3'd0,
        CLS_LW   = 3'd1,
        CLS_SW   = 3'd2,
        CLS_BEQ  = 3'd3,
        CLS_J    = 3'd4,
        CLS_HALT = 3'd5,
        CLS_ILL  = 3'd6
    } op_class_e;

    // Next-PC select codes
    localparam logic [1:0] PC_SEQ    = 2'b00;  // PC + 4
    localparam logic [1:0] PC_BRANCH = 2'b01;  // branch target
    localparam logic [1:0] PC_JUMP   = 2'b10;  // jump target

endpackage

// File: rtl/mcc_op_decode.sv
// ---------------------------------------------------------------------------
// mcc_op_decode
// Purely combinational opcode classifier for the multicycle sequencer.
// Ports:
//   op        in  OP_W  opcode field (top 6 bits used, OP_W >= 6)
//   op_class  out       instruction class (CLS_ILL for undefined opcodes)
// ---------------------------------------------------------------------------
module mcc_op_decode
    import mcc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    output op_class_e       op_class
);

    logic [5:0] opc;
    assign opc = op[OP_W-1 -: 6];

    always_comb begin
        op_class = CLS_ILL;
        if (opc[5:4] == OP_ALU_HI) begin
            op_class = CLS_ALU;
        end else begin
            case (opc)
                OP_SW:   op_class = CLS_SW;
                OP_LW:   op_class = CLS_LW;
                OP_BEQ:  op_class = CLS_BEQ;
                OP_J:    op_class = CLS_J;
                OP_HALT: op_class = CLS_HALT;
                default: op_class = CLS_ILL;
            endcase
        end
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// multi_cycle_ctrl
// Multicycle CPU sequencer. Steps each instruction through IF/ID/EXE/MEM/WB
// and drives the load enables of the stage registers, PC, register file and
// the shared memory port.
//
// Ports:
//   CLK          in   clock, rising edge
//   Reset        in   asynchronous active-low reset
//   op           in   opcode from IR (valid from ID until next IF)
//   zero         in   ALU zero flag, used in EXE of BEQ
//   mem_ready    in   memory completes the current request this cycle
//   mem_req      out  memory request (IF fetch or MEM access)
//   mem_we       out  memory request is a write (SW in MEM)
//   ir_wre       out  IR load enable
//   ab_wre       out  A/B operand register load enable
//   alu_wre      out  ALUout register load enable
//   dbdr_wre     out  data buffer register load enable
//   reg_wre      out  register file write enable
//   pc_wre       out  PC load enable, one pulse per retired instruction
//   pc_src       out  next-PC select (00 PC+4, 01 branch, 10 jump)
//   halted       out  core stopped (HALT or illegal opcode)
//   illegal      out  sticky: stopped on an undefined opcode
//   retired_cnt  out  retired-instruction counter (MCC_PERF_CNT_EN only)
//
// Configuration macro: MCC_PERF_CNT_EN adds retired_cnt, a CNT_W-bit
// wrapping counter that increments on every cycle with pc_wre=1.
//
// Memory handshake: in S_IF and S_MEM mem_req is held high; the request
// completes in the cycle where mem_req=1 and mem_ready=1. mem_ready is
// ignored in all other states.
// ---------------------------------------------------------------------------
module multi_cycle_ctrl
    import mcc_pkg::*;
#(
    parameter int OP_W  = 6,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [OP_W-1:0]  op,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             ir_wre,
    output logic             ab_wre,
    output logic             alu_wre,
    output logic             dbdr_wre,
    output logic             reg_wre,
    output logic             pc_wre,
    output logic [1:0]       pc_src,
    output logic             halted,
    output logic             illegal
`ifdef MCC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] retired_cnt
`endif
);

    state_e    state;
    op_class_e class_q;
    op_class_e cls_d;

    // run is cleared by reset and set on the first edge after release.
    // It keeps every output low while reset is active (the reset state is
    // S_IF, which would otherwise decode to mem_req=1) and makes the first
    // edge after release land in S_IF.
    logic      run;

    mcc_op_decode #(
        .OP_W (OP_W)
    ) u_decode (
        .op       (op),
        .op_class (cls_d)
    );

    // -----------------------------------------------------------------------
    // State register, latched class and sticky illegal flag
    // -----------------------------------------------------------------------
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state   <= S_IF;
            class_q <= CLS_ALU;
            illegal <= 1'b0;
            run     <= 1'b0;
        end else if (!run) begin
            run <= 1'b1;
        end else begin
            case (state)
                S_IF: begin
                    if (mem_ready) state <= S_ID;
                end
                S_ID: begin
                    // class_q holds the class so later op changes are ignored
                    class_q <= cls_d;
                    case (cls_d)
                        CLS_ALU, CLS_LW, CLS_SW, CLS_BEQ: state <= S_EXE;
                        CLS_J:                            state <= S_IF;
                        CLS_HALT:                         state <= S_HALT;
                        default: begin
                            state   <= S_HALT;
                            illegal <= 1'b1;
                        end
                    endcase
                end
                S_EXE: begin
                    case (class_q)
                        CLS_ALU:        state <= S_WB;
                        CLS_LW, CLS_SW: state <= S_MEM;
                        default:        state <= S_IF;   // BEQ resolves here
                    endcase
                end
                S_MEM: begin
                    if (mem_ready) state <= (class_q == CLS_LW) ? S_WB : S_IF;
                end
                S_WB:    state <= S_IF;
                S_HALT:  state <= S_HALT;   // only reset leaves HALT
                default: state <= S_IF;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Output decode: from state, qualified only by mem_ready (IF/MEM),
    // zero (EXE of BEQ) and the decoded class in ID (jump).
    // -----------------------------------------------------------------------
    always_comb begin
        mem_req  = 1'b0;
        mem_we   = 1'b0;
        ir_wre   = 1'b0;
        ab_wre   = 1'b0;
        alu_wre  = 1'b0;
        dbdr_wre = 1'b0;
        reg_wre  = 1'b0;
        pc_wre   = 1'b0;
        pc_src   = PC_SEQ;
        halted   = 1'b0;
        if (run) begin
            case (state)
                S_IF: begin
                    mem_req = 1'b1;
                    ir_wre  = mem_ready;
                end
                S_ID: begin
                    ab_wre = 1'b1;
                    if (cls_d == CLS_J) begin
                        pc_wre = 1'b1;
                        pc_src = PC_JUMP;
                    end
                end
                S_EXE: begin
                    alu_wre = 1'b1;
                    if (class_q == CLS_BEQ) begin
                        pc_wre = 1'b1;
                        pc_src = zero ? PC_BRANCH : PC_SEQ;
                    end
                end
                S_MEM: begin
                    mem_req = 1'b1;
                    mem_we  = (class_q == CLS_SW);
                    if (mem_ready) begin
                        if (class_q == CLS_LW) dbdr_wre = 1'b1;
                        else                   pc_wre   = 1'b1;
                    end
                end
                S_WB: begin
                    reg_wre = 1'b1;
                    pc_wre  = 1'b1;
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MCC_PERF_CNT_EN
    // Retired-instruction counter; wraps naturally at 2^CNT_W.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            retired_cnt <= '0;
        end else if (pc_wre) begin
            retired_cnt <= retired_cnt + 1'b1;
        end
    end
`else
    // CNT_W only sizes the optional counter; keep it referenced so the
    // parameter list stays identical in both builds.
    if (CNT_W < 1) begin : g_cnt_w_unused
    end
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// ---------------------------------------------------------------------------
// tb_multi_cycle_ctrl
// Directed bench for multi_cycle_ctrl: a per-cycle vector table with
// hand-computed expected outputs, plus hand-written sequences for async
// reset mid-instruction, HALT, and (with MCC_PERF_CNT_EN) counter wrap.
// ---------------------------------------------------------------------------
module tb_multi_cycle_ctrl;

    localparam int OP_W = 6;
`ifdef MCC_PERF_CNT_EN
    localparam int CNT_W = 4;
`else
    localparam int CNT_W = 32;
`endif

    // Expected-output bit positions:
    // {mem_req, mem_we, ir_wre, ab_wre, alu_wre, dbdr_wre, reg_wre, pc_wre,
    //  pc_src[1:0], halted, illegal}
    localparam logic [11:0] E_NONE = 12'h000;
    localparam logic [11:0] B_MREQ = 12'h800;
    localparam logic [11:0] B_MWE  = 12'h400;
    localparam logic [11:0] B_IR   = 12'h200;
    localparam logic [11:0] B_AB   = 12'h100;
    localparam logic [11:0] B_ALU  = 12'h080;
    localparam logic [11:0] B_DBDR = 12'h040;
    localparam logic [11:0] B_REG  = 12'h020;
    localparam logic [11:0] B_PC   = 12'h010;
    localparam logic [11:0] S_BR   = 12'h004;
    localparam logic [11:0] S_JMP  = 12'h008;
    localparam logic [11:0] B_HALT = 12'h002;
    localparam logic [11:0] B_ILL  = 12'h001;

    localparam logic [5:0] O_ALU0 = 6'b000000;
    localparam logic [5:0] O_ALU1 = 6'b001011;
    localparam logic [5:0] O_SW   = 6'b110000;
    localparam logic [5:0] O_LW   = 6'b110001;
    localparam logic [5:0] O_BEQ  = 6'b110100;
    localparam logic [5:0] O_J    = 6'b111000;
    localparam logic [5:0] O_HALT = 6'b111111;
    localparam logic [5:0] O_BAD  = 6'b010110;

    // ---------------- clock / reset / DUT ----------------
    logic             CLK = 1'b0;
    logic             Reset = 1'b0;
    logic [OP_W-1:0]  op = '0;
    logic             zero = 1'b0;
    logic             mem_ready = 1'b0;
    logic             mem_req, mem_we, ir_wre, ab_wre, alu_wre, dbdr_wre;
    logic             reg_wre, pc_wre, halted, illegal;
    logic [1:0]       pc_src;
`ifdef MCC_PERF_CNT_EN
    logic [CNT_W-1:0] retired_cnt;
`endif

    always #5 CLK = ~CLK;

    multi_cycle_ctrl #(
        .OP_W  (OP_W),
        .CNT_W (CNT_W)
    ) dut (
        .CLK         (CLK),
        .Reset       (Reset),
        .op          (op),
        .zero        (zero),
        .mem_ready   (mem_ready),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .ir_wre      (ir_wre),
        .ab_wre      (ab_wre),
        .alu_wre     (alu_wre),
        .dbdr_wre    (dbdr_wre),
        .reg_wre     (reg_wre),
        .pc_wre      (pc_wre),
        .pc_src      (pc_src),
        .halted      (halted),
        .illegal     (illegal)
`ifdef MCC_PERF_CNT_EN
        ,
        .retired_cnt (retired_cnt)
`endif
    );

    // ---------------- vector table ----------------
    typedef struct {
        string       name;
        logic [5:0]  op;
        logic        zero;
        logic        mem_ready;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input string n, input logic [5:0] o, input logic z,
                       input logic mr, input logic [11:0] e);
        vec_t v;
        v.name = n;
        v.op = o;
        v.zero = z;
        v.mem_ready = mr;
        v.exp = e;
        vecs.push_back(v);
    endtask

    function automatic logic [11:0] observed();
        return {mem_req, mem_we, ir_wre, ab_wre, alu_wre, dbdr_wre,
                reg_wre, pc_wre, pc_src, halted, illegal};
    endfunction

    task automatic check_out(input string n, input logic [11:0] e);
        logic [11:0] got;
        got = observed();
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL %s: got %03h expected %03h", n, got, e);
        end
    endtask

    // Drive inputs on the falling edge, sample 1 time unit later.
    task automatic step(input logic [5:0] o, input logic z, input logic mr);
        @(negedge CLK);
        op = o;
        zero = z;
        mem_ready = mr;
        #1;
    endtask

    // Assert reset, check outputs are quiet, release; the first rising edge
    // after release is consumed here so the next step() is the IF cycle.
    task automatic do_reset(input string n);
        @(negedge CLK);
        Reset = 1'b0;
        op = '0;
        zero = 1'b0;
        mem_ready = 1'b0;
        #1;
        check_out(n, E_NONE);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
    endtask

    initial begin
        // ALU op=000000: cycles 1..4
        add("alu_if",   O_ALU0, 0, 1, B_MREQ | B_IR);
        add("alu_id",   O_ALU0, 0, 1, B_AB);
        add("alu_exe",  O_ALU0, 0, 1, B_ALU);
        add("alu_wb",   O_ALU0, 0, 1, B_REG | B_PC);
        // ALU where op turns into LW after ID: class held, still WB
        add("alu2_if",  O_ALU1, 0, 1, B_MREQ | B_IR);
        add("alu2_id",  O_ALU1, 1, 1, B_AB);
        add("alu2_exe", O_LW,   1, 1, B_ALU);
        add("alu2_wb",  O_LW,   0, 0, B_REG | B_PC);
        // SW, zero wait
        add("sw_if",    O_SW,   0, 1, B_MREQ | B_IR);
        add("sw_id",    O_SW,   0, 1, B_AB);
        add("sw_exe",   O_SW,   0, 1, B_ALU);
        add("sw_mem",   O_SW,   0, 1, B_MREQ | B_MWE | B_PC);
        // LW with 3 wait cycles in MEM: 8 cycles total
        add("lw_if",    O_LW,   0, 1, B_MREQ | B_IR);
        add("lw_id",    O_LW,   0, 1, B_AB);
        add("lw_exe",   O_LW,   0, 1, B_ALU);
        add("lw_mem_w1",O_LW,   0, 0, B_MREQ);
        add("lw_mem_w2",O_LW,   0, 0, B_MREQ);
        add("lw_mem_w3",O_LW,   0, 0, B_MREQ);
        add("lw_mem_rd",O_LW,   0, 1, B_MREQ | B_DBDR);
        add("lw_wb",    O_LW,   0, 1, B_REG | B_PC);
        // BEQ taken, with one fetch wait cycle first
        add("beq1_ifw", O_BEQ,  1, 0, B_MREQ);
        add("beq1_if",  O_BEQ,  1, 1, B_MREQ | B_IR);
        add("beq1_id",  O_BEQ,  1, 1, B_AB);
        add("beq1_exe", O_BEQ,  1, 1, B_ALU | B_PC | S_BR);
        // BEQ not taken
        add("beq0_if",  O_BEQ,  0, 1, B_MREQ | B_IR);
        add("beq0_id",  O_BEQ,  0, 1, B_AB);
        add("beq0_exe", O_BEQ,  0, 1, B_ALU | B_PC);
        // Jump
        add("j_if",     O_J,    0, 1, B_MREQ | B_IR);
        add("j_id",     O_J,    0, 1, B_AB | B_PC | S_JMP);
        // Undefined opcode -> HALT with illegal
        add("ill_if",   O_BAD,  0, 1, B_MREQ | B_IR);
        add("ill_id",   O_BAD,  0, 1, B_AB);
        add("ill_h1",   O_BAD,  0, 1, B_HALT | B_ILL);
        add("ill_h2",   O_ALU0, 1, 1, B_HALT | B_ILL);

        do_reset("reset_initial");
        foreach (vecs[i]) begin
            step(vecs[i].op, vecs[i].zero, vecs[i].mem_ready);
            check_out(vecs[i].name, vecs[i].exp);
        end

        // Reset asserted mid-MEM of LW: outputs drop immediately
        do_reset("reset_clear_ill");
        step(O_LW, 0, 1); check_out("rst_lw_if", B_MREQ | B_IR);
        step(O_LW, 0, 1); check_out("rst_lw_id", B_AB);
        step(O_LW, 0, 1); check_out("rst_lw_exe", B_ALU);
        step(O_LW, 0, 0); check_out("rst_lw_mem", B_MREQ);
        #2;
        Reset = 1'b0;
        #1;
        check_out("rst_async_drop", E_NONE);
        @(negedge CLK);
        mem_ready = 1'b1;
        #1;
        check_out("rst_held", E_NONE);
        Reset = 1'b1;
        #1;
        check_out("rst_released", E_NONE);
        step(O_LW, 0, 0); check_out("rst_restart_if", B_MREQ);
        step(O_LW, 0, 1); check_out("rst_restart_fetch", B_MREQ | B_IR);

        // HALT opcode: halted without illegal
        do_reset("reset_halt");
        step(O_HALT, 0, 1); check_out("halt_if", B_MREQ | B_IR);
        step(O_HALT, 0, 1); check_out("halt_id", B_AB);
        step(O_HALT, 0, 1); check_out("halt_h1", B_HALT);
        step(O_SW,   1, 1); check_out("halt_h2", B_HALT);

`ifdef MCC_PERF_CNT_EN
        // 17 ALU instructions wrap a 4-bit counter to 1; HALT keeps it
        do_reset("reset_perf");
        checks++;
        if (retired_cnt !== 4'd0) begin
            errors++;
            $display("FAIL perf_reset: got %0d expected 0", retired_cnt);
        end
        for (int n = 0; n < 17; n++) begin
            step(O_ALU0, 0, 1);
            step(O_ALU0, 0, 1);
            step(O_ALU0, 0, 1);
            step(O_ALU0, 0, 1);
        end
        step(O_HALT, 0, 1);
        checks++;
        if (retired_cnt !== 4'd1) begin
            errors++;
            $display("FAIL perf_wrap: got %0d expected 1", retired_cnt);
        end
        step(O_HALT, 0, 1);
        step(O_HALT, 0, 1);
        step(O_HALT, 0, 1);
        step(O_HALT, 0, 1);
        check_out("perf_halted", B_HALT);
        checks++;
        if (retired_cnt !== 4'd1) begin
            errors++;
            $display("FAIL perf_halt_hold: got %0d expected 1", retired_cnt);
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
